// File: rtl/dds_sweep_ctrl.sv
// dds_sweep_ctrl: frequency-sweep sequencer feeding the DDS frequency word.
// Holds start/stop/step/dwell/mode configuration and, on start, walks the
// frequency word through an up, repeating or triangle sweep, holding each
// point for DWELL+1 clocks.
module dds_sweep_ctrl #(
  parameter int FW = 32,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cfg_we,
  input  logic [2:0]    cfg_addr,
  input  logic [31:0]   cfg_data,
  input  logic          start,
  input  logic          abort,
  output logic [FW-1:0] freq_o,
  output logic          freq_we,
  output logic          busy,
  output logic          done,
  output logic          err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    UP   = 2'd1,
    DOWN = 2'd2
  } state_t;

  // Configuration registers
  logic [FW-1:0] f_start_r;
  logic [FW-1:0] f_stop_r;
  logic [FW-1:0] f_step_r;
  logic [DW-1:0] dwell_r;
  logic [1:0]    mode_r;

  // Sweep state and registered outputs
  state_t        state_r, state_nxt_s;
  logic [FW-1:0] freq_r, freq_nxt_s;
  logic          freq_we_r, freq_we_nxt_s;
  logic          busy_r, busy_nxt_s;
  logic          done_r, done_nxt_s;
  logic          err_r, err_nxt_s;
  logic [DW-1:0] cnt_r, cnt_nxt_s;

  // Step arithmetic, one bit wider so carry/borrow ends a leg instead of wrapping
  logic [FW:0]   up_sum_s;
  logic [FW:0]   dn_diff_s;
  logic          up_ok_s;
  logic          dn_ok_s;
  logic          start_ok_s;
  logic          cfg_unused_s;

  // Upper config bits beyond the register widths carry no meaning
  assign cfg_unused_s = ^cfg_data;

  assign up_sum_s   = {1'b0, freq_r} + {1'b0, f_step_r};
  assign dn_diff_s  = {1'b0, freq_r} - {1'b0, f_step_r};
  assign up_ok_s    = (up_sum_s <= {1'b0, f_stop_r});
  assign dn_ok_s    = (!dn_diff_s[FW]) && (dn_diff_s[FW-1:0] >= f_start_r);
  assign start_ok_s = (f_step_r != {FW{1'b0}}) && (f_start_r <= f_stop_r);

  // Config register writes; locked while a sweep runs so the sweep sees stable values
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      f_start_r <= {FW{1'b0}};
      f_stop_r  <= {FW{1'b0}};
      f_step_r  <= {FW{1'b0}};
      dwell_r   <= {DW{1'b0}};
      mode_r    <= 2'b00;
    end else if (cfg_we && !busy_r) begin
      case (cfg_addr)
        3'd0:    f_start_r <= cfg_data[FW-1:0];
        3'd1:    f_stop_r  <= cfg_data[FW-1:0];
        3'd2:    f_step_r  <= cfg_data[FW-1:0];
        3'd3:    dwell_r   <= cfg_data[DW-1:0];
        3'd4:    mode_r    <= cfg_data[1:0];
        default: ;
      endcase
    end
  end

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= IDLE;
      freq_r    <= {FW{1'b0}};
      freq_we_r <= 1'b0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      err_r     <= 1'b0;
      cnt_r     <= {DW{1'b0}};
    end else begin
      state_r   <= state_nxt_s;
      freq_r    <= freq_nxt_s;
      freq_we_r <= freq_we_nxt_s;
      busy_r    <= busy_nxt_s;
      done_r    <= done_nxt_s;
      err_r     <= err_nxt_s;
      cnt_r     <= cnt_nxt_s;
    end
  end

  // Next-state logic: start validation, dwell countdown, leg-end decisions, abort
  always_comb begin
    state_nxt_s   = state_r;
    freq_nxt_s    = freq_r;
    freq_we_nxt_s = 1'b0;
    busy_nxt_s    = busy_r;
    done_nxt_s    = 1'b0;
    err_nxt_s     = 1'b0;
    cnt_nxt_s     = cnt_r;

    case (state_r)
      IDLE: begin
        busy_nxt_s = 1'b0;
        if (abort) begin
          state_nxt_s = IDLE;
        end else if (start) begin
          if (start_ok_s) begin
            state_nxt_s   = UP;
            freq_nxt_s    = f_start_r;
            freq_we_nxt_s = 1'b1;
            busy_nxt_s    = 1'b1;
            cnt_nxt_s     = dwell_r;
          end else begin
            err_nxt_s = 1'b1;
          end
        end else begin
          state_nxt_s = IDLE;
        end
      end

      UP, DOWN: begin
        if (abort) begin
          state_nxt_s = IDLE;
          busy_nxt_s  = 1'b0;
        end else if (cnt_r != {DW{1'b0}}) begin
          cnt_nxt_s = cnt_r - {{(DW-1){1'b0}}, 1'b1};
        end else begin
          // Assume a write happens; the completion branches cancel it
          cnt_nxt_s     = dwell_r;
          freq_we_nxt_s = 1'b1;
          if (state_r == UP && up_ok_s) begin
            freq_nxt_s = up_sum_s[FW-1:0];
          end else if (state_r == DOWN && dn_ok_s) begin
            freq_nxt_s = dn_diff_s[FW-1:0];
          end else begin
            case (mode_r)
              2'b01: begin
                freq_nxt_s  = f_start_r;
                state_nxt_s = UP;
              end
              2'b10: begin
                if (state_r == UP && dn_ok_s) begin
                  freq_nxt_s  = dn_diff_s[FW-1:0];
                  state_nxt_s = DOWN;
                end else begin
                  freq_we_nxt_s = 1'b0;
                  done_nxt_s    = 1'b1;
                  busy_nxt_s    = 1'b0;
                  state_nxt_s   = IDLE;
                end
              end
              2'b11: begin
                if (state_r == UP && dn_ok_s) begin
                  freq_nxt_s  = dn_diff_s[FW-1:0];
                  state_nxt_s = DOWN;
                end else if (state_r == DOWN && up_ok_s) begin
                  freq_nxt_s  = up_sum_s[FW-1:0];
                  state_nxt_s = UP;
                end else begin
                  freq_nxt_s  = f_start_r;
                  state_nxt_s = UP;
                end
              end
              default: begin
                freq_we_nxt_s = 1'b0;
                done_nxt_s    = 1'b1;
                busy_nxt_s    = 1'b0;
                state_nxt_s   = IDLE;
              end
            endcase
          end
        end
      end

      default: begin
        state_nxt_s = IDLE;
        busy_nxt_s  = 1'b0;
      end
    endcase
  end

  assign freq_o  = freq_r;
  assign freq_we = freq_we_r;
  assign busy    = busy_r;
  assign done    = done_r;
  assign err     = err_r;

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// Directed self-checking bench for dds_sweep_ctrl. Cycle 0 is the cycle in
// which start is held high; outputs are sampled 1 ns after each rising edge.
module tb_dds_sweep_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cfg_we = 1'b0;
  logic [2:0]  cfg_addr = 3'd0;
  logic [31:0] cfg_data = 32'd0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [31:0] freq_o;
  logic        freq_we;
  logic        busy;
  logic        done;
  logic        err;

  int errors = 0;
  int checks = 0;

  // Per-run observations
  int          we_n;
  int          we_cyc [16];
  logic [31:0] we_frq [16];
  int          done_n, done_c, err_n, err_c, busy_n, busy_first, busy_last;
  logic [31:0] freq_end;

  int exp3 [7] = '{1000, 1100, 1200, 1300, 1200, 1100, 1000};

  dds_sweep_ctrl #(.FW(32), .DW(16)) dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
    .cfg_data(cfg_data), .start(start), .abort(abort), .freq_o(freq_o),
    .freq_we(freq_we), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  task automatic cfg_write(input logic [2:0] a, input logic [31:0] d);
    @(posedge clk); #1;
    cfg_we = 1'b1; cfg_addr = a; cfg_data = d;
    @(posedge clk); #1;
    cfg_we = 1'b0;
  endtask

  task automatic set_cfg(input logic [31:0] fs, input logic [31:0] fe,
                         input logic [31:0] st, input logic [31:0] dw,
                         input logic [31:0] md);
    cfg_write(3'd0, fs);
    cfg_write(3'd1, fe);
    cfg_write(3'd2, st);
    cfg_write(3'd3, dw);
    cfg_write(3'd4, md);
  endtask

  // Start at cycle 0, optional abort and F_START write at given cycles, observe len cycles
  task automatic run(input int len, input int abort_at, input int cfg_at, input logic [31:0] cfg_val);
    we_n = 0; done_n = 0; done_c = -1; err_n = 0; err_c = -1;
    busy_n = 0; busy_first = -1; busy_last = -1;
    @(posedge clk); #1;
    start = 1'b1;
    abort = (abort_at == 0);
    for (int n = 1; n <= len; n++) begin
      @(posedge clk); #1;
      start  = 1'b0;
      abort  = (n == abort_at);
      cfg_we = (n == cfg_at);
      cfg_addr = 3'd0;
      cfg_data = cfg_val;
      if (freq_we) begin
        if (we_n < 16) begin
          we_cyc[we_n] = n;
          we_frq[we_n] = freq_o;
        end
        we_n++;
      end
      if (done) begin
        if (done_c < 0) done_c = n;
        done_n++;
      end
      if (err) begin
        if (err_c < 0) err_c = n;
        err_n++;
      end
      if (busy) begin
        if (busy_first < 0) busy_first = n;
        busy_last = n;
        busy_n++;
      end
    end
    abort  = 1'b0;
    cfg_we = 1'b0;
    freq_end = freq_o;
  endtask

  initial begin
    #2;
    check_eq("rst_freq", freq_o, 0);
    check_eq("rst_we", freq_we, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_err", err, 0);
    #20 rst = 1'b0;

    // 1: basic up sweep
    set_cfg(1000, 1300, 100, 3, 0);
    run(40, -1, -1, 0);
    check_eq("t1_we_n", we_n, 4);
    for (int i = 0; i < 4; i++) begin
      check_eq($sformatf("t1_cyc%0d", i), we_cyc[i], 1 + 4 * i);
      check_eq($sformatf("t1_frq%0d", i), we_frq[i], 1000 + 100 * i);
    end
    check_eq("t1_done_c", done_c, 17);
    check_eq("t1_done_n", done_n, 1);
    check_eq("t1_busy_first", busy_first, 1);
    check_eq("t1_busy_last", busy_last, 16);
    check_eq("t1_busy_n", busy_n, 16);

    // 2: stop not on a step boundary, no clamping
    cfg_write(3'd1, 1250);
    run(40, -1, -1, 0);
    check_eq("t2_we_n", we_n, 3);
    check_eq("t2_frq2", we_frq[2], 1200);
    check_eq("t2_cyc2", we_cyc[2], 9);
    check_eq("t2_done_c", done_c, 13);
    check_eq("t2_freq_end", freq_end, 1200);

    // 3: triangle, single pass
    set_cfg(1000, 1300, 100, 3, 2);
    run(40, -1, -1, 0);
    check_eq("t3_we_n", we_n, 7);
    for (int i = 0; i < 7; i++) begin
      check_eq($sformatf("t3_cyc%0d", i), we_cyc[i], 1 + 4 * i);
      check_eq($sformatf("t3_frq%0d", i), we_frq[i], exp3[i]);
    end
    check_eq("t3_done_c", done_c, 29);

    // 4: top-of-range, carry ends the leg
    set_cfg(32'hFFFFFF00, 32'hFFFFFFFF, 32'h80, 3, 0);
    run(20, -1, -1, 0);
    check_eq("t4_we_n", we_n, 2);
    check_eq("t4_frq0", we_frq[0], 32'hFFFFFF00);
    check_eq("t4_frq1", we_frq[1], 32'hFFFFFF80);
    check_eq("t4_done_c", done_c, 9);
    check_eq("t4_freq_end", freq_end, 32'hFFFFFF80);

    // 5a: repeat mode wraps back to F_START at cycle 17, aborted later
    set_cfg(1000, 1300, 100, 3, 1);
    run(30, 20, -1, 0);
    check_eq("t5a_we_n", we_n, 5);
    check_eq("t5a_cyc4", we_cyc[4], 17);
    check_eq("t5a_frq4", we_frq[4], 1000);
    check_eq("t5a_busy_last", busy_last, 20);
    check_eq("t5a_done_n", done_n, 0);

    // 5b: abort at cycle 15
    run(30, 15, -1, 0);
    check_eq("t5b_we_n", we_n, 4);
    check_eq("t5b_last_we", we_cyc[3], 13);
    check_eq("t5b_busy_last", busy_last, 15);
    check_eq("t5b_done_n", done_n, 0);
    check_eq("t5b_freq_end", freq_end, 1300);

    // 6: zero step rejected
    cfg_write(3'd2, 0);
    run(10, -1, -1, 0);
    check_eq("t6_err_c", err_c, 1);
    check_eq("t6_err_n", err_n, 1);
    check_eq("t6_we_n", we_n, 0);
    check_eq("t6_busy_n", busy_n, 0);

    // abort together with rejected start: no err
    run(10, 0, -1, 0);
    check_eq("t6b_err_n", err_n, 0);
    check_eq("t6b_we_n", we_n, 0);

    // start > stop also rejected
    set_cfg(2000, 1300, 100, 3, 0);
    run(10, -1, -1, 0);
    check_eq("t6c_err_c", err_c, 1);
    check_eq("t6c_we_n", we_n, 0);

    // cfg write during sweep ignored
    set_cfg(1000, 1300, 100, 3, 0);
    run(40, -1, 3, 500);
    check_eq("t7_frq0", we_frq[0], 1000);
    check_eq("t7_we_n", we_n, 4);
    run(40, -1, -1, 0);
    check_eq("t7_next_frq0", we_frq[0], 1000);
    check_eq("t7_next_frq3", we_frq[3], 1300);

    // reset mid-sweep returns outputs at once
    @(posedge clk); #1; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (5) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check_eq("rst_mid_freq", freq_o, 0);
    check_eq("rst_mid_busy", busy, 0);
    check_eq("rst_mid_we", freq_we, 0);
    #20 rst = 1'b0;
    run(10, -1, -1, 0);
    check_eq("rst_cfg_cleared_err", err_c, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
